// File: rtl/calc1_pkg.sv
// Shared codes, sizes and port-state encoding for the calc1 request arbiter.
package calc1_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int NPORTS     = 4;

  localparam logic [3:0] CMD_NONE = 4'd0;
  localparam logic [3:0] CMD_ADD  = 4'd1;
  localparam logic [3:0] CMD_SUB  = 4'd2;
  localparam logic [3:0] CMD_SHL  = 4'd5;
  localparam logic [3:0] CMD_SHR  = 4'd6;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OP2,
    ST_PEND,
    ST_ISSUED
  } port_st_e;

endpackage

// File: rtl/calc1_alu.sv
// Pipelined calc1 ALU: result computed at issue, then carried ALU_LAT stages
// together with the originating port tag.
module calc1_alu import calc1_pkg::*; #(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ALU_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              vld_i,
  input  logic [3:0]        cmd_i,
  input  logic [DATA_W-1:0] op1_i,
  input  logic [DATA_W-1:0] op2_i,
  input  logic [1:0]        tag_i,
  output logic              vld_o,
  output logic [DATA_W-1:0] res_o,
  output logic [1:0]        resp_o,
  output logic [1:0]        tag_o
);

  logic [DATA_W-1:0] res_c;
  logic [1:0]        resp_c;
  logic [DATA_W:0]   sum_c;

  logic [ALU_LAT:1]             vld_pipe;
  logic [ALU_LAT:1][DATA_W-1:0] res_pipe;
  logic [ALU_LAT:1][1:0]        resp_pipe;
  logic [ALU_LAT:1][1:0]        tag_pipe;

  // Arithmetic and overflow rules; anything not recognised is an error with zero data.
  always_comb begin
    res_c  = '0;
    resp_c = RESP_ERR;
    sum_c  = {1'b0, op1_i} + {1'b0, op2_i};
    case (cmd_i)
      CMD_ADD: if (!sum_c[DATA_W]) begin
        res_c  = sum_c[DATA_W-1:0];
        resp_c = RESP_OK;
      end
      CMD_SUB: if (op2_i <= op1_i) begin
        res_c  = op1_i - op2_i;
        resp_c = RESP_OK;
      end
      CMD_SHL: begin
        res_c  = op1_i << op2_i[4:0];
        resp_c = RESP_OK;
      end
      CMD_SHR: begin
        res_c  = op1_i >> op2_i[4:0];
        resp_c = RESP_OK;
      end
      default: ;
    endcase
  end

  // Shift register of valid/result/tag; reset drops everything in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe  <= '0;
      res_pipe  <= '0;
      resp_pipe <= '0;
      tag_pipe  <= '0;
    end else begin
      vld_pipe[1]  <= vld_i;
      res_pipe[1]  <= res_c;
      resp_pipe[1] <= resp_c;
      tag_pipe[1]  <= tag_i;
      for (int s = 2; s <= ALU_LAT; s++) begin
        vld_pipe[s]  <= vld_pipe[s-1];
        res_pipe[s]  <= res_pipe[s-1];
        resp_pipe[s] <= resp_pipe[s-1];
        tag_pipe[s]  <= tag_pipe[s-1];
      end
    end
  end

  assign vld_o  = vld_pipe[ALU_LAT];
  assign res_o  = res_pipe[ALU_LAT];
  assign resp_o = resp_pipe[ALU_LAT];
  assign tag_o  = tag_pipe[ALU_LAT];

endmodule

// File: rtl/calc1_req_arbiter.sv
// Four calc1 requester ports sharing one ALU through a round-robin arbiter.
module calc1_req_arbiter import calc1_pkg::*; #(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ALU_LAT = 1
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [0:3]        req1_cmd_in,
  input  logic [0:3]        req2_cmd_in,
  input  logic [0:3]        req3_cmd_in,
  input  logic [0:3]        req4_cmd_in,
  input  logic [0:DATA_W-1] req1_data_in,
  input  logic [0:DATA_W-1] req2_data_in,
  input  logic [0:DATA_W-1] req3_data_in,
  input  logic [0:DATA_W-1] req4_data_in,
  output logic [0:DATA_W-1] out_data1,
  output logic [0:DATA_W-1] out_data2,
  output logic [0:DATA_W-1] out_data3,
  output logic [0:DATA_W-1] out_data4,
  output logic [0:1]        out_resp1,
  output logic [0:1]        out_resp2,
  output logic [0:1]        out_resp3,
  output logic [0:1]        out_resp4,
  output logic [1:4]        proto_err
);

  // Index 0 is port 1 throughout.
  logic [NPORTS-1:0][3:0]        cmd_in;
  logic [NPORTS-1:0][DATA_W-1:0] dat_in;

  assign cmd_in = {req4_cmd_in, req3_cmd_in, req2_cmd_in, req1_cmd_in};
  assign dat_in = {req4_data_in, req3_data_in, req2_data_in, req1_data_in};

  port_st_e st_q [NPORTS];
  port_st_e st_d [NPORTS];

  logic [NPORTS-1:0][3:0]        cmd_q;
  logic [NPORTS-1:0][DATA_W-1:0] op1_q, op2_q;
  logic [NPORTS-1:0]             err_q;
  logic [NPORTS-1:0]             ld_op1, ld_op2, err_set, pend;
  logic                          ready_q;

  logic [1:0] ptr_q;
  logic       gnt_vld;
  logic [1:0] gnt_idx;

  logic              alu_vld;
  logic [DATA_W-1:0] alu_res;
  logic [1:0]        alu_resp, alu_tag;

  logic [NPORTS-1:0][DATA_W-1:0] rsp_data_q;
  logic [NPORTS-1:0][1:0]        rsp_resp_q;

  // Gates command capture off for the first edge after reset release.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) ready_q <= 1'b0;
    else        ready_q <= 1'b1;
  end

  // Per-port next state, load strobes and busy-port protocol errors.
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      st_d[p]    = st_q[p];
      ld_op1[p]  = 1'b0;
      ld_op2[p]  = 1'b0;
      err_set[p] = 1'b0;
      pend[p]    = (st_q[p] == ST_PEND);
      case (st_q[p])
        ST_IDLE: if (ready_q && cmd_in[p] != CMD_NONE) begin
          st_d[p]   = ST_OP2;
          ld_op1[p] = 1'b1;
        end
        ST_OP2: begin
          st_d[p]   = ST_PEND;
          ld_op2[p] = 1'b1;
        end
        ST_PEND:   if (gnt_vld && gnt_idx == 2'(p)) st_d[p] = ST_ISSUED;
        ST_ISSUED: if (alu_vld && alu_tag == 2'(p)) st_d[p] = ST_IDLE;
        default:   st_d[p] = ST_IDLE;
      endcase
      if (st_q[p] != ST_IDLE && cmd_in[p] != CMD_NONE) err_set[p] = 1'b1;
    end
  end

  // Port state registers.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < NPORTS; p++) st_q[p] <= ST_IDLE;
    end else begin
      for (int p = 0; p < NPORTS; p++) st_q[p] <= st_d[p];
    end
  end

  // Captured command/operands and sticky protocol-error flags.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      cmd_q <= '0;
      op1_q <= '0;
      op2_q <= '0;
      err_q <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (ld_op1[p]) begin
          cmd_q[p] <= cmd_in[p];
          op1_q[p] <= dat_in[p];
        end
        if (ld_op2[p])  op2_q[p] <= dat_in[p];
        if (err_set[p]) err_q[p] <= 1'b1;
      end
    end
  end

  // Round-robin search starting one past the last granted port.
  always_comb begin
    logic [1:0] cand;
    cand    = '0;
    gnt_vld = 1'b0;
    gnt_idx = ptr_q;
    for (int k = 1; k <= NPORTS; k++) begin
      cand = ptr_q + 2'(k);
      if (!gnt_vld && pend[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // Pointer moves only on a grant; reset points at port 4 so port 1 wins first.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset)       ptr_q <= 2'd3;
    else if (gnt_vld) ptr_q <= gnt_idx;
  end

  calc1_alu #(
    .DATA_W  (DATA_W),
    .ALU_LAT (ALU_LAT)
  ) u_alu (
    .clk_i  (c_clk),
    .rst_ni (reset),
    .vld_i  (gnt_vld),
    .cmd_i  (cmd_q[gnt_idx]),
    .op1_i  (op1_q[gnt_idx]),
    .op2_i  (op2_q[gnt_idx]),
    .tag_i  (gnt_idx),
    .vld_o  (alu_vld),
    .res_o  (alu_res),
    .resp_o (alu_resp),
    .tag_o  (alu_tag)
  );

  // One-cycle response registers; idle ports read back zero.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      rsp_data_q <= '0;
      rsp_resp_q <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (alu_vld && alu_tag == 2'(p)) begin
          rsp_data_q[p] <= alu_res;
          rsp_resp_q[p] <= alu_resp;
        end else begin
          rsp_data_q[p] <= '0;
          rsp_resp_q[p] <= RESP_NONE;
        end
      end
    end
  end

  assign out_data1 = rsp_data_q[0];
  assign out_data2 = rsp_data_q[1];
  assign out_data3 = rsp_data_q[2];
  assign out_data4 = rsp_data_q[3];
  assign out_resp1 = rsp_resp_q[0];
  assign out_resp2 = rsp_resp_q[1];
  assign out_resp3 = rsp_resp_q[2];
  assign out_resp4 = rsp_resp_q[3];
  assign proto_err = {err_q[0], err_q[1], err_q[2], err_q[3]};

endmodule

// File: tb/tb_calc1_req_arbiter.sv
// Directed bench for calc1_req_arbiter: vector table plus multi-cycle sequences.
module tb_calc1_req_arbiter;

  logic        c_clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  cmd_a [4];
  logic [31:0] din_a [4];
  logic [31:0] od    [4];
  logic [1:0]  orsp  [4];
  logic [3:0]  perr;
  int checks = 0;
  int errors = 0;

  always #5 c_clk = ~c_clk;

  calc1_req_arbiter #(.DATA_W(32), .ALU_LAT(1)) dut (
    .c_clk        (c_clk),
    .reset        (reset),
    .req1_cmd_in  (cmd_a[0]),
    .req2_cmd_in  (cmd_a[1]),
    .req3_cmd_in  (cmd_a[2]),
    .req4_cmd_in  (cmd_a[3]),
    .req1_data_in (din_a[0]),
    .req2_data_in (din_a[1]),
    .req3_data_in (din_a[2]),
    .req4_data_in (din_a[3]),
    .out_data1    (od[0]),
    .out_data2    (od[1]),
    .out_data3    (od[2]),
    .out_data4    (od[3]),
    .out_resp1    (orsp[0]),
    .out_resp2    (orsp[1]),
    .out_resp3    (orsp[2]),
    .out_resp4    (orsp[3]),
    .proto_err    (perr)
  );

  typedef struct {
    int          port;
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [1:0]  resp;
    logic [31:0] data;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // All ports except 'skip' must show no response and zero data.
  task automatic chk_idle(input string nm, input int skip);
    for (int q = 0; q < 4; q++) begin
      if (q != skip) begin
        chk($sformatf("%s resp%0d", nm, q + 1), {30'b0, orsp[q]}, 32'h0);
        chk($sformatf("%s data%0d", nm, q + 1), od[q], 32'h0);
      end
    end
  endtask

  // Single request: drive cmd/op1, then op2, expect response after E3 for one cycle.
  task automatic run_vec(input string nm, input vec_t v);
    @(negedge c_clk); cmd_a[v.port] = v.cmd;  din_a[v.port] = v.op1;
    @(negedge c_clk); cmd_a[v.port] = 4'd0;   din_a[v.port] = v.op2;
    @(negedge c_clk); din_a[v.port] = 32'h0;
    @(negedge c_clk); chk_idle({nm, " early"}, -1);
    @(negedge c_clk);
    chk({nm, " resp"}, {30'b0, orsp[v.port]}, {30'b0, v.resp});
    chk({nm, " data"}, od[v.port], v.data);
    chk_idle({nm, " others"}, v.port);
    @(negedge c_clk); chk_idle({nm, " after"}, -1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v4;
    tbl[0] = '{0, 4'd1, 32'h0000_0008, 32'h0000_0003, 2'd1, 32'h0000_000B};
    tbl[1] = '{1, 4'd1, 32'h8000_0000, 32'h8000_0000, 2'd2, 32'h0000_0000};
    tbl[2] = '{2, 4'd2, 32'h0000_0003, 32'h0000_0005, 2'd2, 32'h0000_0000};
    tbl[3] = '{0, 4'd6, 32'h0000_0F00, 32'h0000_0025, 2'd1, 32'h0000_0078};
    tbl[4] = '{1, 4'd3, 32'h0000_0007, 32'h0000_0009, 2'd2, 32'h0000_0000};
    tbl[5] = '{0, 4'd1, 32'h0000_0000, 32'h0000_0000, 2'd1, 32'h0000_0000};
    tbl[6] = '{2, 4'd2, 32'h0000_1234, 32'h0000_1234, 2'd1, 32'h0000_0000};
    tbl[7] = '{1, 4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0000_0000};
    tbl[8] = '{2, 4'd2, 32'h0000_0005, 32'h0000_0003, 2'd1, 32'h0000_0002};
    tbl[9] = '{3, 4'd5, 32'h0000_0001, 32'h0000_001F, 2'd1, 32'h8000_0000};

    for (int q = 0; q < 4; q++) begin cmd_a[q] = 4'd0; din_a[q] = 32'h0; end

    // Reset state
    @(negedge c_clk); @(negedge c_clk);
    chk_idle("reset", -1);
    chk("reset perr", {28'b0, perr}, 32'h0);
    reset = 1'b1;
    @(negedge c_clk); @(negedge c_clk);

    // Table vectors (last one on port 4 leaves the pointer at 4)
    for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

    // All four ports add 1+1 together, twice: order 1,2,3,4 each round
    for (int r = 0; r < 2; r++) begin
      @(negedge c_clk);
      for (int q = 0; q < 4; q++) begin cmd_a[q] = 4'd1; din_a[q] = 32'h1; end
      @(negedge c_clk);
      for (int q = 0; q < 4; q++) cmd_a[q] = 4'd0;
      @(negedge c_clk);
      for (int q = 0; q < 4; q++) din_a[q] = 32'h0;
      @(negedge c_clk); chk_idle($sformatf("rr%0d early", r), -1);
      for (int c = 0; c < 4; c++) begin
        @(negedge c_clk);
        for (int q = 0; q < 4; q++) begin
          chk($sformatf("rr%0d c%0d resp%0d", r, c, q + 1), {30'b0, orsp[q]}, (q == c) ? 32'h1 : 32'h0);
          chk($sformatf("rr%0d c%0d data%0d", r, c, q + 1), od[q], (q == c) ? 32'h2 : 32'h0);
        end
      end
      @(negedge c_clk); chk_idle($sformatf("rr%0d after", r), -1);
    end

    // Last grant = port 2, then ports 1 and 3 pending together: port 3 first
    run_vec("pre-p2", tbl[4]);
    @(negedge c_clk);
    cmd_a[0] = 4'd1; din_a[0] = 32'd2; cmd_a[2] = 4'd1; din_a[2] = 32'd10;
    @(negedge c_clk);
    cmd_a[0] = 4'd0; din_a[0] = 32'd3; cmd_a[2] = 4'd0; din_a[2] = 32'd20;
    @(negedge c_clk); din_a[0] = 32'h0; din_a[2] = 32'h0;
    @(negedge c_clk); chk_idle("rr13 early", -1);
    @(negedge c_clk);
    chk("rr13 first resp3", {30'b0, orsp[2]}, 32'h1);
    chk("rr13 first data3", od[2], 32'd30);
    chk("rr13 first resp1", {30'b0, orsp[0]}, 32'h0);
    @(negedge c_clk);
    chk("rr13 second resp1", {30'b0, orsp[0]}, 32'h1);
    chk("rr13 second data1", od[0], 32'd5);
    chk("rr13 second resp3", {30'b0, orsp[2]}, 32'h0);

    // Port 1 re-sends a cmd while pending: error flag, single correct response
    @(negedge c_clk); cmd_a[0] = 4'd1; din_a[0] = 32'd4;
    @(negedge c_clk); cmd_a[0] = 4'd0; din_a[0] = 32'd5;
    @(negedge c_clk); cmd_a[0] = 4'd1; din_a[0] = 32'hDEAD;
    @(negedge c_clk); cmd_a[0] = 4'd0; din_a[0] = 32'h0;
    chk("busy perr", {28'b0, perr}, 32'h8);
    @(negedge c_clk);
    chk("busy resp1", {30'b0, orsp[0]}, 32'h1);
    chk("busy data1", od[0], 32'd9);
    for (int c = 0; c < 4; c++) begin
      @(negedge c_clk); chk_idle($sformatf("busy quiet%0d", c), -1);
    end
    chk("busy perr sticky", {28'b0, perr}, 32'h8);

    // Reset after E1 on ports 1 and 2: nothing ever responds
    @(negedge c_clk);
    cmd_a[0] = 4'd1; din_a[0] = 32'd1; cmd_a[1] = 4'd2; din_a[1] = 32'd9;
    @(negedge c_clk);
    cmd_a[0] = 4'd0; din_a[0] = 32'd1; cmd_a[1] = 4'd0; din_a[1] = 32'd3;
    @(negedge c_clk); din_a[0] = 32'h0; din_a[1] = 32'h0;
    #2 reset = 1'b0;
    #1;
    chk_idle("midrst", -1);
    chk("midrst perr", {28'b0, perr}, 32'h0);
    @(negedge c_clk); @(negedge c_clk);
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge c_clk); chk_idle($sformatf("postrst%0d", c), -1);
    end
    v4 = '{3, 4'd1, 32'h0000_0010, 32'h0000_0020, 2'd1, 32'h0000_0030};
    run_vec("postrst p4", v4);
    chk("postrst perr", {28'b0, perr}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
